// File: rtl/sobel_pipe.sv
// Three-stage pipelined Sobel |Gx|+|Gy| unit with fill/row-boundary qualification.
// Optional binary threshold output enabled by defining SOBEL_THRESH_EN.
module sobel_pipe #(
  parameter int unsigned COLS = 640
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic [71:0] matrix,
  input  logic [7:0]  threshold,
  output logic        out_valid,
  output logic [7:0]  edge_out,
  output logic [10:0] out_hcount,
  output logic [9:0]  out_vcount
);

  localparam logic [10:0] FULL = 11'(2 * COLS + 2);

  logic [10:0] fill_cnt;
  logic        full_now;
  logic        q0;

  logic [7:0]  z [9];
  logic [10:0] gx_pos, gx_neg, gy_pos, gy_neg;

  logic signed [10:0] gx1, gy1;
  logic               q1;
  logic [10:0]        h1;
  logic [9:0]         v1;

  logic [10:0] gx_abs, gy_abs;
  logic [9:0]  ax2, ay2;
  logic        q2;
  logic [10:0] h2;
  logic [9:0]  v2;

  logic [10:0] mag;
  logic [7:0]  result;

  // The pixel that completes the fill is itself qualified, so look at the post-increment count.
  always_comb begin
    full_now = (fill_cnt == FULL) || (in_valid && (fill_cnt == FULL - 11'd1));
    q0       = in_valid && full_now && (hcount >= 11'd2);
  end

  always_comb begin
    for (int unsigned i = 0; i < 9; i++) begin
      z[i] = matrix[8*i +: 8];
    end
    gx_pos = {3'b000, z[6]} + {2'b00, z[3], 1'b0} + {3'b000, z[0]};
    gx_neg = {3'b000, z[8]} + {2'b00, z[5], 1'b0} + {3'b000, z[2]};
    gy_pos = {3'b000, z[8]} + {2'b00, z[7], 1'b0} + {3'b000, z[6]};
    gy_neg = {3'b000, z[2]} + {2'b00, z[1], 1'b0} + {3'b000, z[0]};
  end

  always_comb begin
    gx_abs = gx1[10] ? 11'(-gx1) : 11'(gx1);
    gy_abs = gy1[10] ? 11'(-gy1) : 11'(gy1);
  end

  always_comb begin
    mag = {1'b0, ax2} + {1'b0, ay2};
`ifdef SOBEL_THRESH_EN
    result = (mag >= {3'b000, threshold}) ? 8'hFF : 8'h00;
`else
    result = (mag > 11'd255) ? 8'hFF : mag[7:0];
`endif
  end

`ifndef SOBEL_THRESH_EN
  logic unused_threshold;
  assign unused_threshold = ^threshold;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      fill_cnt   <= '0;
      gx1        <= '0;
      gy1        <= '0;
      q1         <= 1'b0;
      h1         <= '0;
      v1         <= '0;
      ax2        <= '0;
      ay2        <= '0;
      q2         <= 1'b0;
      h2         <= '0;
      v2         <= '0;
      out_valid  <= 1'b0;
      edge_out   <= '0;
      out_hcount <= '0;
      out_vcount <= '0;
    end else begin
      if (in_valid && (fill_cnt != FULL)) begin
        fill_cnt <= fill_cnt + 11'd1;
      end
      gx1        <= $signed(gx_pos - gx_neg);
      gy1        <= $signed(gy_pos - gy_neg);
      q1         <= q0;
      h1         <= hcount;
      v1         <= vcount;
      ax2        <= gx_abs[9:0];
      ay2        <= gy_abs[9:0];
      q2         <= q1;
      h2         <= h1;
      v2         <= v1;
      out_valid  <= q2;
      edge_out   <= q2 ? result : 8'h00;
      out_hcount <= h2;
      out_vcount <= v2;
    end
  end

endmodule

// File: tb/tb_sobel_pipe.sv
// Randomized scoreboard bench for sobel_pipe (COLS=8); honours SOBEL_THRESH_EN.
module tb_sobel_pipe;

  localparam int COLS = 8;
  localparam int FULL = 2 * COLS + 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [71:0] matrix;
  logic [7:0]  threshold;
  logic        out_valid;
  logic [7:0]  edge_out;
  logic [10:0] out_hcount;
  logic [9:0]  out_vcount;

  sobel_pipe #(.COLS(COLS)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .hcount     (hcount),
    .vcount     (vcount),
    .matrix     (matrix),
    .threshold  (threshold),
    .out_valid  (out_valid),
    .edge_out   (edge_out),
    .out_hcount (out_hcount),
    .out_vcount (out_vcount)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          launch;
    logic        valid;
    logic [7:0]  edg;
    logic [10:0] h;
    logic [9:0]  v;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   fill = 0;
  int   pix = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [7:0] ref_edge(input logic [71:0] m, input logic [7:0] thr);
    int z[9];
    int gx, gy, mag;
    for (int i = 0; i < 9; i++) z[i] = int'(m[8*i +: 8]);
    gx  = (z[6] + 2*z[3] + z[0]) - (z[8] + 2*z[5] + z[2]);
    gy  = (z[8] + 2*z[7] + z[6]) - (z[2] + 2*z[1] + z[0]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_THRESH_EN
    return (mag >= int'(thr)) ? 8'hFF : 8'h00;
`else
    if (thr == 8'd0) mag = mag;  // threshold has no effect in this build
    return (mag > 255) ? 8'hFF : 8'(mag);
`endif
  endfunction

  function automatic logic [71:0] pattern(input int kind);
    logic [71:0] m;
    logic [7:0]  u;
    case (kind)
      1: begin
        u = 8'd100;
        m = {9{u}};
      end
      2: begin  // left column dark, rest bright
        m = '1;
        m[71:64] = 8'd0; m[47:40] = 8'd0; m[23:16] = 8'd0;
      end
      3: begin  // right column 10, rest 0
        m = '0;
        m[55:48] = 8'd10; m[31:24] = 8'd10; m[7:0] = 8'd10;
      end
      4: begin
        u = 8'($urandom_range(0, 255));
        m = {9{u}};
      end
      default: m = {8'($urandom), 32'($urandom), 32'($urandom)};
    endcase
    return m;
  endfunction

  task automatic step(input bit rst, input bit inv, input int kind);
    exp_t e;
    int   h, v, sel;
    @(posedge clock);
    #1;
    sel = $urandom_range(0, 2);
    h   = inv ? pix % COLS : $urandom_range(0, 2047);
    v   = inv ? pix / COLS : $urandom_range(0, 1023);
    reset     = rst;
    in_valid  = inv;
    hcount    = 11'(h);
    vcount    = 10'(v);
    matrix    = pattern(kind);
    threshold = (sel == 0) ? 8'd30 : (sel == 1) ? 8'd41 : 8'($urandom_range(0, 255));
    e.launch = cyc;
    if (rst) begin
      fill = 0;
      pix  = 0;
      // Results still in flight are wiped by the reset edge.
      for (int k = sbq.size() - 2; k < sbq.size(); k++) begin
        if (k >= 0) begin
          exp_t t;
          t = sbq[k];
          t.valid = 1'b0; t.edg = '0; t.h = '0; t.v = '0;
          sbq[k] = t;
        end
      end
      e.valid = 1'b0; e.edg = '0; e.h = '0; e.v = '0;
    end else begin
      if (inv) begin
        if (fill < FULL) fill++;
        pix++;
      end
      e.valid = inv && (fill == FULL) && (h >= 2);
      e.edg   = e.valid ? ref_edge(matrix, threshold) : 8'h00;
      e.h     = 11'(h);
      e.v     = 10'(v);
    end
    sbq.push_back(e);
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    while (sbq.size() > 0 && sbq[0].launch + 3 <= cyc) begin
      e = sbq.pop_front();
      n_cmp++;
      if (e.launch + 3 != cyc) begin
        n_bad++;
        $display("FAIL latency launch=%0d seen_at=%0d required_at=%0d", e.launch, cyc, e.launch + 3);
      end else if ({out_valid, edge_out, out_hcount, out_vcount} !== {e.valid, e.edg, e.h, e.v}) begin
        n_bad++;
        $display("FAIL out@%0d got valid=%0b edge=%0d h=%0d v=%0d required valid=%0b edge=%0d h=%0d v=%0d",
                 cyc, out_valid, edge_out, out_hcount, out_vcount, e.valid, e.edg, e.h, e.v);
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; hcount = '0; vcount = '0; matrix = '0; threshold = '0;
    repeat (2) step(1, 0, 0);
    for (int i = 0; i < 60; i++) step(0, 1, $urandom_range(0, 4));
    for (int i = 0; i < 40; i++) step(0, (i % 2) == 0, $urandom_range(0, 4));
    for (int i = 0; i < 10; i++) step(0, 1, $urandom_range(0, 4));
    step(1, 1, 0);
    for (int i = 0; i < 40; i++) step(0, 1, $urandom_range(0, 4));
    for (int i = 0; i < 300; i++) step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 4));
    for (int i = 0; i < 6; i++) step(0, 0, 0);
    repeat (5) @(posedge clock);
    #1;
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d required=0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sobel_pipe.md
# sobel_pipe

Three-stage pipelined Sobel gradient unit sitting directly downstream of the 3-row pixel shift register in the edge-detection path. Each clock it consumes the 72-bit 3x3 greyscale window and computes |Gx|+|Gy|, saturated to 8 bits, with an optional binary threshold. It forwards delay-matched pixel coordinates and suppresses output until the window is fully populated and does not straddle a row boundary.

## Interface
- COLS, 640, pixels per row; must match the upstream shift register row length
- clock  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  matrix/hcount/vcount qualify an active-video pixel this cycle
- hcount  in  11  column of newest pixel z0
- vcount  in  10  row of newest pixel z0
- matrix  in  72  window {z8,z7,z6,z5,z4,z3,z2,z1,z0}; [71:64]=z8 … [7:0]=z0; rows z8-z6 (top), z5-z3, z2-z0 (bottom); z8/z5/z2 left (oldest) column
- threshold  in  8  edge threshold, used only when SOBEL_THRESH_EN is defined
- out_valid  out  1  edge_out is a valid result
- edge_out  out  8  gradient magnitude or binary edge value
- out_hcount  out  11  hcount delayed to align with edge_out
- out_vcount  out  10  vcount delayed to align with edge_out

## Operation
- Stage 1 (S1), registered: gx = (z6 + 2·z3 + z0) − (z8 + 2·z5 + z2); gy = (z8 + 2·z7 + z6) − (z2 + 2·z1 + z0). Both 11-bit signed, range −1020..+1020, no overflow.
- Stage 2 (S2), registered: ax = |gx|, ay = |gy|, 10-bit unsigned, max 1020.
- Stage 3 (S3), registered: mag = ax + ay, 11 bits, max 2040; sat = (mag > 255) ? 255 : mag[7:0].
- Fill counter: 11-bit, increments on each in_valid cycle, saturates at 2·COLS+2. Window is full when counter == 2·COLS+2.
- Pixel qualify at S1 entry: q = in_valid & full & (hcount >= 2). Columns 0 and 1 are not qualified because their window wraps across rows.
- q, hcount and vcount travel through the three stages alongside the data.
- Unqualified results: out_valid = 0, edge_out = 0. Coordinates still propagate.
- in_valid = 0 does not stall the pipeline. Stages advance every clock, and bubbles emerge as out_valid = 0.
- The fill counter never resets within a frame. It is cleared only by reset.

## Timing
- Latency is exactly 3 clocks from matrix sampled at edge N to edge_out/out_valid updated at edge N+3. Throughput is 1 pixel/clock.
- Reset, sampled at a rising edge, forces all pipeline registers, the fill counter, out_valid, edge_out, out_hcount and out_vcount to 0 at that edge.
- Reset mid-operation: in-flight results are discarded, out_valid is 0 for at least 3 clocks after reset deasserts, and the fill restarts from 0.
- Boundary: the first qualified output appears 3 clocks after the in_valid cycle that brings the counter to 2·COLS+2, provided hcount >= 2 in that cycle.
- Saturation: mag = 256..2040 yields 255. mag = 255 yields 255. The threshold comparison is registered in S3 and adds no latency.

## Configuration
- SOBEL_THRESH_EN defined: edge_out = (mag >= threshold) ? 8'hFF : 8'h00 for qualified pixels. Comparison is on the full 11-bit mag, with threshold zero-extended.
- SOBEL_THRESH_EN undefined: edge_out = sat, and the threshold port is ignored (unused).
- Latency, reset and qualification behaviour are identical in both builds.

## Test plan
- Uniform window, all z = 100, after fill -> out_valid = 1, edge_out = 0, exactly 3 clocks after input.
- Vertical edge, left column 0 and others 255 -> gx = 1020, gy = 0, edge_out = 255 (saturated).
- Right column 10, others 0, macro off -> gx = 40, edge_out = 40. Same input with the macro on and threshold = 30 -> 255; threshold = 41 -> 0.
- Reset then continuous in_valid at COLS = 8 -> out_valid stays 0 for the first 18 pixel cycles and at hcount 0/1. It asserts 3 clocks after the first qualified pixel. out_hcount/out_vcount equal the input values delayed by 3 clocks.
- Reset asserted mid-row while out_valid = 1 -> next edge all outputs 0, and no out_valid until a full refill.
- in_valid toggled 1/0 every clock -> out_valid mirrors the qualified pattern delayed by 3 clocks, and the fill counter counts only in_valid cycles.
